// File: rtl/sig_debounce_pkg.sv
// rtl/sig_debounce_pkg.sv - shared types and sizing helpers for the debounce filter
package sig_debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_CHK_HI = 2'd1,
    S_HIGH   = 2'd2,
    S_CHK_LO = 2'd3
  } state_t;

  localparam int MIN_STABLE_CYCLES = 2;

  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchroniser, reset value 0
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/sig_debounce.sv
// rtl/sig_debounce.sv - glitch filter with rise/fall pulses and accepted-edge counter
module sig_debounce
  import sig_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  output logic             y,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [CNT_W-1:0] edge_cnt
);

  // Out-of-range settings are clamped so the qualify window is never shorter than two samples.
  localparam int SC = (STABLE_CYCLES < MIN_STABLE_CYCLES) ? MIN_STABLE_CYCLES : STABLE_CYCLES;
  localparam int CW = cnt_width(SC);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SC - 1);

  logic          a_s;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          y_nxt, rise_nxt, fall_nxt, busy_nxt;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (a),
    .q     (a_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      S_LOW: begin
        if (a_s) begin
          state_nxt = S_CHK_HI;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = '0;
        end
      end
      S_CHK_HI: begin
        if (!a_s) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HIGH;
          rise_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!a_s) begin
          state_nxt = S_CHK_LO;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = '0;
        end
      end
      S_CHK_LO: begin
        if (a_s) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_LOW;
          fall_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = S_LOW;
        cnt_nxt   = '0;
      end
    endcase
    // Outputs are flopped from the next state so they line up with the state register.
    y_nxt    = (state_nxt == S_HIGH) || (state_nxt == S_CHK_LO);
    busy_nxt = (state_nxt == S_CHK_HI) || (state_nxt == S_CHK_LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_LOW;
      cnt      <= '0;
      y        <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      busy     <= 1'b0;
      edge_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      y     <= y_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
      busy  <= busy_nxt;
      if (rise_nxt || fall_nxt) begin
        edge_cnt <= edge_cnt + CNT_W'(1);
      end
    end
  end

endmodule
